tail_light_monitor: RTL and testbench

- Passive checker and decoder on the tail-light lamp bus: samples the 3+3 lamp vectors driven by the tail-light sequencer and decodes the active mode and sweep phase.
- Flags illegal lamp patterns, illegal step-to-step transitions and stalled sweeps, and counts completed sweeps and errors.
- Sits beside the sequencer, in silicon as a fault monitor and on the bench as a scoreboard; it never drives the lamps.

---
 rtl/tail_light_monitor_if.sv | 37 +++
 rtl/tail_light_monitor.sv | 193 +++++++++++++++++++
 tb/tb_tail_light_monitor.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tail_light_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_monitor_if
// Brief    : Lamp-bus bundle between the tail-light sequencer side (master)
//            and the passive tail-light monitor (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface tail_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic             obs_en;
    logic [2:0]       Lcba;
    logic [2:0]       Rabc;
    logic             clr;
    logic [1:0]       mode;
    logic [1:0]       phase;
    logic             sweep_done;
    logic             pattern_err;
    logic             seq_err;
    logic             stall_err;
    logic             fault;
    logic [CNT_W-1:0] sweep_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output obs_en, Lcba, Rabc, clr,
        input  mode, phase, sweep_done, pattern_err, seq_err, stall_err,
               fault, sweep_count, err_count
    );

    modport slave (
        input  obs_en, Lcba, Rabc, clr,
        output mode, phase, sweep_done, pattern_err, seq_err, stall_err,
               fault, sweep_count, err_count
    );
endinterface
`default_nettype wire

// File: rtl/tail_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_monitor
// Brief    : Passive checker/decoder for the tail-light lamp bus. Decodes
//            mode and sweep phase, flags illegal patterns, illegal step
//            transitions and stalled sweeps, and counts sweeps and errors.
//            A sample (with its clr) is captured on one edge and its
//            registered response is produced on the following edge.
// Revision : 1.0 - initial release
// ============================================================================
module tail_light_monitor #(
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    tail_light_monitor_if.slave   bus
);
    localparam int               c_STALL_W   = $clog2(STALL_MAX + 1);
    localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(STALL_MAX);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        ST_OFF, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_HZ, ST_UNK
    } state_t;

    // Capture stage
    logic       smp_vld_q;
    logic [2:0] smp_l_q;
    logic [2:0] smp_r_q;
    logic       smp_clr_q;

    // Response stage
    state_t                 prev_q, prev_d;
    logic [1:0]             mode_q, mode_d;
    logic [1:0]             phase_q, phase_d;
    logic                   sweep_q, sweep_d;
    logic                   pat_q, pat_d;
    logic                   seq_q, seq_d;
    logic                   stall_q, stall_d;
    logic                   fault_q, fault_d;
    logic [CNT_W-1:0]       sc_q, sc_d;
    logic [CNT_W-1:0]       ec_q, ec_d;
    logic [c_STALL_W-1:0]   scnt_q, scnt_d;

    state_t w_cur;
    logic   w_legal;
    logic   w_err_any;

    // Register the raw lamp sample, its strobe and the clear request together
    always_ff @(posedge clk) begin
        if (reset) begin
            smp_vld_q <= 1'b0;
            smp_l_q   <= 3'b000;
            smp_r_q   <= 3'b000;
            smp_clr_q <= 1'b0;
        end else begin
            smp_vld_q <= bus.obs_en;
            smp_l_q   <= bus.Lcba;
            smp_r_q   <= bus.Rabc;
            smp_clr_q <= bus.clr;
        end
    end

    // Decode the captured {Lcba, Rabc} pair; anything unlisted is illegal
    always_comb begin
        w_cur = ST_UNK;
        case ({smp_l_q, smp_r_q})
            6'b000_000: w_cur = ST_OFF;
            6'b001_000: w_cur = ST_L1;
            6'b011_000: w_cur = ST_L2;
            6'b111_000: w_cur = ST_L3;
            6'b000_100: w_cur = ST_R1;
            6'b000_110: w_cur = ST_R2;
            6'b000_111: w_cur = ST_R3;
            6'b111_111: w_cur = ST_HZ;
            default:    w_cur = ST_UNK;
        endcase
    end

    // Legality of prev -> cur; UNK accepts anything so the monitor resyncs
    always_comb begin
        w_legal = 1'b1;
        if (prev_q != ST_UNK) begin
            case (w_cur)
                ST_L2:   w_legal = (prev_q == ST_L1) || (prev_q == ST_L2);
                ST_L3:   w_legal = (prev_q == ST_L2) || (prev_q == ST_L3);
                ST_R2:   w_legal = (prev_q == ST_R1) || (prev_q == ST_R2);
                ST_R3:   w_legal = (prev_q == ST_R2) || (prev_q == ST_R3);
                default: w_legal = 1'b1;
            endcase
        end
    end

    // Next-state for the checker: decode, pulses, stall tracking, counters
    always_comb begin
        prev_d  = prev_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        scnt_d  = scnt_q;
        sweep_d = 1'b0;
        pat_d   = 1'b0;
        seq_d   = 1'b0;
        stall_d = 1'b0;

        if (smp_vld_q) begin
            if (w_cur == ST_UNK) begin
                pat_d  = 1'b1;
                prev_d = ST_UNK;
                scnt_d = '0;
            end else begin
                seq_d   = ~w_legal;
                sweep_d = ((prev_q == ST_L2) && (w_cur == ST_L3)) ||
                          ((prev_q == ST_R2) && (w_cur == ST_R3));
                prev_d  = w_cur;
                case (w_cur)
                    ST_L1:   begin mode_d = 2'd1; phase_d = 2'd1; end
                    ST_L2:   begin mode_d = 2'd1; phase_d = 2'd2; end
                    ST_L3:   begin mode_d = 2'd1; phase_d = 2'd3; end
                    ST_R1:   begin mode_d = 2'd2; phase_d = 2'd1; end
                    ST_R2:   begin mode_d = 2'd2; phase_d = 2'd2; end
                    ST_R3:   begin mode_d = 2'd2; phase_d = 2'd3; end
                    ST_HZ:   begin mode_d = 2'd3; phase_d = 2'd0; end
                    default: begin mode_d = 2'd0; phase_d = 2'd0; end
                endcase
                // Only a held sweep step counts toward a stall; the counter
                // parks at the limit so the pulse fires exactly once.
                if ((w_cur == prev_q) &&
                    (w_cur inside {ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3})) begin
                    if (scnt_q != c_STALL_MAX) begin
                        scnt_d  = scnt_q + 1'b1;
                        stall_d = ((scnt_q + 1'b1) == c_STALL_MAX);
                    end
                end else begin
                    scnt_d = '0;
                end
            end
        end

        w_err_any = pat_d | seq_d | stall_d;

        // A clear coinciding with a new event leaves that event counted
        if (smp_clr_q) begin
            sc_d    = CNT_W'(sweep_d);
            ec_d    = CNT_W'(w_err_any);
            fault_d = w_err_any;
        end else begin
            sc_d    = (sweep_d && (sc_q != c_CNT_MAX)) ? sc_q + 1'b1 : sc_q;
            ec_d    = (w_err_any && (ec_q != c_CNT_MAX)) ? ec_q + 1'b1 : ec_q;
            fault_d = fault_q | w_err_any;
        end
    end

    // Registered checker state and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= ST_OFF;
            mode_q  <= 2'd0;
            phase_q <= 2'd0;
            sweep_q <= 1'b0;
            pat_q   <= 1'b0;
            seq_q   <= 1'b0;
            stall_q <= 1'b0;
            fault_q <= 1'b0;
            sc_q    <= '0;
            ec_q    <= '0;
            scnt_q  <= '0;
        end else begin
            prev_q  <= prev_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            sweep_q <= sweep_d;
            pat_q   <= pat_d;
            seq_q   <= seq_d;
            stall_q <= stall_d;
            fault_q <= fault_d;
            sc_q    <= sc_d;
            ec_q    <= ec_d;
            scnt_q  <= scnt_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.phase       = phase_q;
    assign bus.sweep_done  = sweep_q;
    assign bus.pattern_err = pat_q;
    assign bus.seq_err     = seq_q;
    assign bus.stall_err   = stall_q;
    assign bus.fault       = fault_q;
    assign bus.sweep_count = sc_q;
    assign bus.err_count   = ec_q;
endmodule
`default_nettype wire

// File: tb/tb_tail_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tail_light_monitor
// Brief    : Self-checking bench for tail_light_monitor (CNT_W=2, STALL_MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tail_light_monitor;
    localparam int CW   = 2;
    localparam int SMAX = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [1:0]    mode;
        logic [1:0]    phase;
        logic          sd;
        logic          pe;
        logic          se;
        logic          ste;
        logic          flt;
        logic [CW-1:0] sc;
        logic [CW-1:0] ec;
    } resp_t;

    logic clk;
    logic reset;
    tail_light_monitor_if #(.CNT_W(CW)) bus ();

    tail_light_monitor #(.CNT_W(CW), .STALL_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec  = 0;
    int    n_miss = 0;
    resp_t exp_q[$];
    string tag_q[$];

    // Reference model state: 0=OFF 1..3=L1..L3 4..6=R1..R3 7=HZ 8=UNK
    int   m_prev, m_mode, m_phase, m_stall, m_sc, m_ec;
    logic m_fault;

    function automatic int decode(input logic [2:0] l, input logic [2:0] r);
        if (r == 3'b000) begin
            case (l)
                3'b000:  return 0;
                3'b001:  return 1;
                3'b011:  return 2;
                3'b111:  return 3;
                default: return 8;
            endcase
        end
        if (l == 3'b000) begin
            case (r)
                3'b100:  return 4;
                3'b110:  return 5;
                3'b111:  return 6;
                default: return 8;
            endcase
        end
        if (l == 3'b111 && r == 3'b111) return 7;
        return 8;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_mode = 0; m_phase = 0; m_stall = 0;
        m_sc = 0; m_ec = 0; m_fault = 1'b0;
    endtask

    task automatic model_step(input bit en, input logic [2:0] l, input logic [2:0] r,
                              input bit c, output resp_t e);
        int  cur;
        bit  ok, err;
        e = '0;
        if (en) begin
            cur = decode(l, r);
            if (cur == 8) begin
                e.pe = 1'b1; m_prev = 8; m_stall = 0;
            end else begin
                ok = (m_prev == 8) || (cur == m_prev) ||
                     (cur == 0) || (cur == 1) || (cur == 4) || (cur == 7) ||
                     (cur == m_prev + 1);
                e.se = !ok;
                e.sd = (m_prev == 2 && cur == 3) || (m_prev == 5 && cur == 6);
                if (cur == m_prev && cur >= 1 && cur <= 6) begin
                    if (m_stall < SMAX) begin
                        m_stall++;
                        if (m_stall == SMAX) e.ste = 1'b1;
                    end
                end else begin
                    m_stall = 0;
                end
                m_mode  = (cur == 0) ? 0 : (cur <= 3) ? 1 : (cur <= 6) ? 2 : 3;
                m_phase = (cur >= 1 && cur <= 3) ? cur : (cur >= 4 && cur <= 6) ? cur - 3 : 0;
                m_prev  = cur;
            end
        end
        err = e.pe | e.se | e.ste;
        if (c) begin
            m_sc = e.sd; m_ec = err; m_fault = err;
        end else begin
            if (e.sd && m_sc < CMAX) m_sc++;
            if (err && m_ec < CMAX) m_ec++;
            m_fault = m_fault | err;
        end
        e.mode  = 2'(m_mode);
        e.phase = 2'(m_phase);
        e.flt   = m_fault;
        e.sc    = CW'(m_sc);
        e.ec    = CW'(m_ec);
    endtask

    function automatic resp_t observe();
        resp_t o;
        o.mode  = bus.mode;
        o.phase = bus.phase;
        o.sd    = bus.sweep_done;
        o.pe    = bus.pattern_err;
        o.se    = bus.seq_err;
        o.ste   = bus.stall_err;
        o.flt   = bus.fault;
        o.sc    = bus.sweep_count;
        o.ec    = bus.err_count;
        return o;
    endfunction

    task automatic compare(input string tag, input resp_t exp_r);
        resp_t o;
        o = observe();
        n_vec++;
        assert (o === exp_r) else begin
            n_miss++;
            $error("FAIL %s: observed mode=%0d phase=%0d sd=%b pe=%b se=%b st=%b fault=%b sc=%0d ec=%0d, expected mode=%0d phase=%0d sd=%b pe=%b se=%b st=%b fault=%b sc=%0d ec=%0d",
                   tag, o.mode, o.phase, o.sd, o.pe, o.se, o.ste, o.flt, o.sc, o.ec,
                   exp_r.mode, exp_r.phase, exp_r.sd, exp_r.pe, exp_r.se, exp_r.ste,
                   exp_r.flt, exp_r.sc, exp_r.ec);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one sample (called just after a falling edge), queue its expected
    // response, and check the response of the sample two edges older.
    task automatic step(input string tag, input bit en, input logic [2:0] l,
                        input logic [2:0] r, input bit c);
        resp_t e;
        bus.obs_en = en; bus.Lcba = l; bus.Rabc = r; bus.clr = c;
        model_step(en, l, r, c, e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        if (exp_q.size() == 2) compare(tag_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.obs_en = 1'b0; bus.Lcba = 3'b000; bus.Rabc = 3'b000; bus.clr = 1'b0;
        @(negedge clk);
        compare("reset", resp_t'(0));
        @(negedge clk);
        exp_q.delete();
        tag_q.delete();
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.obs_en = 1'b0; bus.Lcba = 3'b000; bus.Rabc = 3'b000; bus.clr = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Left sweep
        step("lsw_off", 1, 3'b000, 3'b000, 0);
        step("lsw_l1",  1, 3'b001, 3'b000, 0);
        step("lsw_l2",  1, 3'b011, 3'b000, 0);
        step("lsw_l3",  1, 3'b111, 3'b000, 0);
        step("lsw_l1b", 1, 3'b001, 3'b000, 0);
        step("lsw_l2b", 1, 3'b011, 3'b000, 0);
        step("lsw_l3b", 1, 3'b111, 3'b000, 0);
        idle(2);
        chk("lsw_count", int'(bus.sweep_count), 2);
        chk("lsw_fault", int'(bus.fault), 0);

        // Illegal pattern then resync onto R2
        step("pat_l1",  1, 3'b001, 3'b000, 0);
        step("pat_bad", 1, 3'b010, 3'b001, 0);
        step("pat_r2",  1, 3'b000, 3'b110, 0);
        idle(2);
        chk("pat_mode", int'(bus.mode), 2);
        chk("pat_phase", int'(bus.phase), 2);
        chk("pat_errc", int'(bus.err_count), 1);

        // Illegal transitions, then clear
        step("seq_clr", 0, 3'b000, 3'b000, 1);
        step("seq_off", 1, 3'b000, 3'b000, 0);
        step("seq_l3",  1, 3'b111, 3'b000, 0);
        step("seq_r3",  1, 3'b000, 3'b111, 0);
        idle(2);
        chk("seq_errc", int'(bus.err_count), 2);
        chk("seq_fault", int'(bus.fault), 1);
        step("seq_clr2", 0, 3'b000, 3'b000, 1);
        idle(2);
        chk("clr_errc", int'(bus.err_count), 0);
        chk("clr_fault", int'(bus.fault), 0);

        // Stall on R2, hazard never stalls
        step("st_r1", 1, 3'b000, 3'b100, 0);
        for (int i = 0; i < 6; i++) step("st_r2", 1, 3'b000, 3'b110, 0);
        for (int i = 0; i < 20; i++) step("st_hz", 1, 3'b111, 3'b111, 0);
        idle(2);
        chk("st_errc", int'(bus.err_count), 1);
        chk("st_mode", int'(bus.mode), 3);

        // Clear coinciding with an error, then error-count saturation
        step("ce_bad", 1, 3'b101, 3'b000, 1);
        idle(2);
        chk("ce_errc", int'(bus.err_count), 1);
        chk("ce_fault", int'(bus.fault), 1);
        for (int i = 0; i < 4; i++) step("es_bad", 1, 3'b000, 3'b011, 0);
        idle(2);
        chk("es_errc", int'(bus.err_count), CMAX);

        // Gating with garbage on the lamps
        step("g_l1", 1, 3'b001, 3'b000, 0);
        step("g_l2", 1, 3'b011, 3'b000, 0);
        for (int i = 0; i < 3; i++)
            step("g_off", 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0);
        step("g_l3", 1, 3'b111, 3'b000, 0);
        idle(2);

        // Reset mid-sweep, then L2 is checked from OFF
        step("rs_l1", 1, 3'b001, 3'b000, 0);
        step("rs_l2", 1, 3'b011, 3'b000, 0);
        idle(1);
        do_reset();
        step("rs_l2b", 1, 3'b011, 3'b000, 0);
        step("rs_chk", 0, 3'b000, 3'b000, 0);
        chk("rs_seq", int'(bus.seq_err), 1);
        chk("rs_mode", int'(bus.mode), 1);
        chk("rs_phase", int'(bus.phase), 2);
        idle(1);

        // Sweep-count saturation
        for (int i = 0; i < 5; i++) begin
            step("sat_l1", 1, 3'b001, 3'b000, 0);
            step("sat_l2", 1, 3'b011, 3'b000, 0);
            step("sat_l3", 1, 3'b111, 3'b000, 0);
        end
        idle(2);
        chk("sat_sc", int'(bus.sweep_count), CMAX);
        step("sat_clr", 0, 3'b000, 3'b000, 1);
        idle(2);
        chk("sat_clr_sc", int'(bus.sweep_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
